mmio_accel_bridge: RTL and testbench
====================================

Name: mmio_accel_bridge

Overview:
- Memory-mapped peripheral on the barrel-datapath external MEM-stage port. That port carries loads/stores whose address bits [9:8] are non-zero.
- Consumes the datapath's mem_addr_out, mem_data_out and mem_we. Returns load data one cycle later on mem_datat_in, which the datapath muxes into WB.
- Bridges CPU stores/loads to a hardware accelerator through two FIFOs: a TX command stream and an RX result stream, both valid/ready.

Parameters:
- FIFO_DEPTH, 8: entries per FIFO; power of 2, >= 2.
- D_WIDTH, 64: data width of the CPU port and the streams.
- REGION, 2'b01: value of addr[9:8] decoded as this block.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- mem_addr_in  in  10  byte address from the MEM stage
- mem_wdata_in  in  D_WIDTH  store data
- mem_we_in  in  1  store strobe, one cycle per store
- mem_rdata_out  out  D_WIDTH  registered load data (feeds mem_datat_in)
- acc_tx_data  out  D_WIDTH  TX FIFO head
- acc_tx_valid  out  1  TX FIFO not empty
- acc_tx_ready  in  1  accelerator accepts TX head
- acc_rx_data  in  D_WIDTH  result from accelerator
- acc_rx_valid  in  1  result valid
- acc_rx_ready  out  1  RX FIFO not full

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. On reset:
  - both FIFOs empty, pointers and counts 0
  - sticky error register 0
  - mem_rdata_out 0; acc_tx_valid 0; acc_rx_ready 0 for that cycle, then 1
  - acc_tx_data is don't-care while acc_tx_valid is 0
- Reset mid-operation discards all FIFO contents; no partial beats.
- Decode: selected when mem_addr_in[9:8]==REGION. Offset is mem_addr_in[7:0]; only word-aligned offsets below are defined.
- Register map:
  - 0x00 TX_DATA: write pushes mem_wdata_in; read 0.
  - 0x04 RX_DATA: read returns RX head, 0 if empty; no pop.
  - 0x08 RX_POP: write pops one RX entry; data ignored; read 0.
  - 0x0C STATUS, read:
    - [3:0] {tx_full, tx_empty, rx_full, rx_empty}
    - [15:8] tx_count
    - [23:16] rx_count
    - other bits 0
    - writes ignored
  - 0x10 ERR, read: bit0 = TX push while full, bit1 = RX pop while empty; sticky. A write with wdata[k]=1 clears bit k.
- Unselected or undefined addresses: read 0; writes have no effect.
- Reads have no side effects. The address bus is sampled every cycle.
- Read latency is exactly 1 cycle: mem_rdata_out at edge N+1 reflects the address at edge N and register/FIFO state before any update at edge N.
- TX push:
  - accepted when selected, mem_we_in=1, offset 0x00 and tx_count<FIFO_DEPTH, all evaluated on pre-edge state
  - otherwise the data is dropped and ERR bit0 is set
  - a simultaneous accelerator pop does not rescue a push to a full FIFO
- TX pop: acc_tx_valid & acc_tx_ready at an edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push to an empty FIFO: acc_tx_valid rises on the next cycle (no fall-through).
- RX push: acc_rx_valid & acc_rx_ready.
- RX pop: RX_POP write with rx_count>0; otherwise ERR bit1 is set. Simultaneous push/pop obey the same rules as TX.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits and saturate at neither end, because errors block over/underflow.
- STATUS count fields are zero-extended to 8 bits.
- Storage is a register array. FIFO_DEPTH up to 64 is supported.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- With it defined:
  - extra output irq (1 bit) and register 0x14 IRQ_EN (bits [1:0], read/write, reset 0)
  - irq = registered (IRQ_EN[0] & !rx_empty) | (IRQ_EN[1] & tx_empty), one cycle after the state change
  - irq resets to 0
- Without it: no irq port; offset 0x14 behaves as undefined (reads 0).

Test Plan:
- Reset, then read STATUS at 0x10C -> mem_rdata_out = 0x0000_0000_0000_0005 one cycle later; acc_tx_valid=0, acc_rx_ready=1.
- Store 0xA5 to 0x100 with acc_tx_ready=0 -> acc_tx_valid=1 next cycle, acc_tx_data=0xA5, STATUS tx_count=1. Raise ready -> valid drops after one beat.
- Store 9 words to 0x100 with FIFO_DEPTH=8 and ready=0 -> tx_count=8, tx_full=1, ERR=0x1. Write 0x1 to 0x110 -> ERR=0.
- Accelerator drives 0x11, 0x22 -> read 0x104 returns 0x11. Write 0x108, read 0x104 -> 0x22. Two more pops -> rx_empty=1, ERR bit1=1.
- Fill and drain TX 3x FIFO_DEPTH with ready toggling every cycle -> output order matches input order across pointer wrap; count never exceeds 8.
- Store to 0x000 and 0x204 -> no FIFO change, reads return 0. With MMIO_IRQ_EN: IRQ_EN=1 plus one RX beat -> irq=1 the next cycle; pop -> irq=0.

Source files
------------

// File: rtl/mmio_accel_bridge_if.sv
// mmio_accel_bridge_if: bundles the MEM-stage bus and the accelerator TX/RX
// streams of mmio_accel_bridge.
//   mem_addr_in/mem_wdata_in/mem_we_in : CPU load/store request
//   mem_rdata_out                      : registered load data
//   acc_tx_data/valid/ready            : command stream to the accelerator
//   acc_rx_data/valid/ready            : result stream from the accelerator
// slave modport is the bridge's view; master is the CPU/accelerator side.
interface mmio_accel_bridge_if #(
    parameter int D_WIDTH = 64
);
    logic [9:0]         mem_addr_in;
    logic [D_WIDTH-1:0] mem_wdata_in;
    logic               mem_we_in;
    logic [D_WIDTH-1:0] mem_rdata_out;
    logic [D_WIDTH-1:0] acc_tx_data;
    logic               acc_tx_valid;
    logic               acc_tx_ready;
    logic [D_WIDTH-1:0] acc_rx_data;
    logic               acc_rx_valid;
    logic               acc_rx_ready;

    modport slave (
        input  mem_addr_in, mem_wdata_in, mem_we_in, acc_tx_ready,
               acc_rx_data, acc_rx_valid,
        output mem_rdata_out, acc_tx_data, acc_tx_valid, acc_rx_ready
    );

    modport master (
        output mem_addr_in, mem_wdata_in, mem_we_in, acc_tx_ready,
               acc_rx_data, acc_rx_valid,
        input  mem_rdata_out, acc_tx_data, acc_tx_valid, acc_rx_ready
    );
endinterface

// File: rtl/mmio_accel_bridge.sv
// mmio_accel_bridge: memory-mapped bridge between the datapath MEM-stage port
// and an accelerator, via a TX command FIFO and an RX result FIFO.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : mmio_accel_bridge_if.slave (CPU bus + TX/RX streams)
//   irq          : interrupt output, present only with MMIO_IRQ_EN defined
// Register map (offset = addr[7:0], selected when addr[9:8] == REGION):
//   0x00 TX_DATA (w push), 0x04 RX_DATA (r head), 0x08 RX_POP (w),
//   0x0C STATUS (r), 0x10 ERR (r, write-1-to-clear), 0x14 IRQ_EN (MMIO_IRQ_EN)
// Loads return one cycle later from pre-edge state; reads have no side effects.
module mmio_accel_bridge #(
    parameter int         FIFO_DEPTH = 8,
    parameter int         D_WIDTH    = 64,
    parameter logic [1:0] REGION     = 2'b01
) (
    input  logic clk,
    input  logic reset_n,
`ifdef MMIO_IRQ_EN
    output logic irq,
`endif
    mmio_accel_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][D_WIDTH-1:0] tx_mem_q, tx_mem_d, rx_mem_q, rx_mem_d;
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [1:0]    err_q, err_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic          rx_rdy_q, rx_rdy_d;
`ifdef MMIO_IRQ_EN
    logic [1:0]    irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
`endif

    logic       sel;
    logic [7:0] off;
    logic       wr_tx, wr_pop, wr_err;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop;

    assign sel    = bus.mem_addr_in[9:8] == REGION;
    assign off    = bus.mem_addr_in[7:0];
    assign wr_tx  = sel & bus.mem_we_in & (off == 8'h00);
    assign wr_pop = sel & bus.mem_we_in & (off == 8'h08);
    assign wr_err = sel & bus.mem_we_in & (off == 8'h10);

    assign tx_full  = tx_cnt_q == FULL;
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == FULL;
    assign rx_empty = rx_cnt_q == '0;

    // Fullness is judged on pre-edge state, so a same-cycle accelerator pop
    // never makes room for a push into a full TX FIFO.
    assign tx_push = wr_tx & ~tx_full;
    assign tx_pop  = ~tx_empty & bus.acc_tx_ready;
    assign rx_push = bus.acc_rx_valid & rx_rdy_q;
    assign rx_pop  = wr_pop & ~rx_empty;

    assign bus.acc_tx_valid  = ~tx_empty;
    assign bus.acc_tx_data   = tx_mem_q[tx_rd_q];
    assign bus.acc_rx_ready  = rx_rdy_q;
    assign bus.mem_rdata_out = rdata_q;
`ifdef MMIO_IRQ_EN
    assign irq = irq_q;
`endif

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = bus.mem_wdata_in;
            tx_wr_d = tx_wr_q + AW'(1);
        end
        if (tx_pop) tx_rd_d = tx_rd_q + AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = bus.acc_rx_data;
            rx_wr_d = rx_wr_q + AW'(1);
        end
        if (rx_pop) rx_rd_d = rx_rd_q + AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        // Registered so ready stays low for the reset cycle itself.
        rx_rdy_d = rx_cnt_d != FULL;
    end

    always_comb begin
        err_d = err_q;
        if (wr_err) err_d = err_q & ~bus.mem_wdata_in[1:0];
        if (wr_tx & tx_full)   err_d[0] = 1'b1;
        if (wr_pop & rx_empty) err_d[1] = 1'b1;
`ifdef MMIO_IRQ_EN
        irq_en_d = irq_en_q;
        if (sel & bus.mem_we_in & (off == 8'h14)) irq_en_d = bus.mem_wdata_in[1:0];
        irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
`endif
    end

    always_comb begin
        rdata_d = '0;
        if (sel) begin
            case (off)
                8'h04: if (!rx_empty) rdata_d = rx_mem_q[rx_rd_q];
                8'h0C: rdata_d = D_WIDTH'({8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                                           tx_full, tx_empty, rx_full, rx_empty});
                8'h10: rdata_d = D_WIDTH'(err_q);
`ifdef MMIO_IRQ_EN
                8'h14: rdata_d = D_WIDTH'(irq_en_q);
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            rx_rdy_q <= 1'b0;
`ifdef MMIO_IRQ_EN
            irq_en_q <= '0;
            irq_q    <= 1'b0;
`endif
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rx_rdy_q <= rx_rdy_d;
`ifdef MMIO_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
`endif
        end
    end

    // Storage needs no reset: entries are only visible through the counts.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end
endmodule

// File: tb/tb_mmio_accel_bridge.sv
module tb_mmio_accel_bridge;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n;
`ifdef MMIO_IRQ_EN
    logic irq;
`endif
    always #5 clk = ~clk;

    mmio_accel_bridge_if #(.D_WIDTH(64)) bus ();

    mmio_accel_bridge #(.FIFO_DEPTH(DEPTH), .D_WIDTH(64), .REGION(2'b01)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef MMIO_IRQ_EN
        .irq(irq),
`endif
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    // reference model state
    logic [63:0] txq[$];
    logic [63:0] rxq[$];
    bit   [1:0]  err_m, en_m;
    bit          rdy_m, irq_m;
    logic [63:0] exp_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        chk("rdata", bus.mem_rdata_out, exp_rd);
        chk("tx_valid", 64'(bus.acc_tx_valid), 64'(txq.size() != 0));
        if (txq.size() != 0) chk("tx_data", bus.acc_tx_data, txq[0]);
        chk("rx_ready", 64'(bus.acc_rx_ready), 64'(rdy_m));
`ifdef MMIO_IRQ_EN
        chk("irq", 64'(irq), 64'(irq_m));
`endif
    endtask

    task automatic idle_inputs();
        bus.mem_addr_in  = '0;
        bus.mem_wdata_in = '0;
        bus.mem_we_in    = 1'b0;
        bus.acc_tx_ready = 1'b0;
        bus.acc_rx_valid = 1'b0;
        bus.acc_rx_data  = '0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            txq.delete(); rxq.delete();
            err_m = 0; en_m = 0; rdy_m = 0; irq_m = 0; exp_rd = 0;
            compare();
        end
        reset_n = 1'b1;
    endtask

    // One clock: drive inputs, predict from pre-edge model state, compare after edge.
    task automatic step(input logic [9:0] a, input bit we, input logic [63:0] wd,
                        input bit txr, input bit rxv, input logic [63:0] rxd);
        bit sel, irq_n, tx_pop, tx_push, rx_pop, rx_push;
        logic [7:0] off;
        int nt, nr;
        bus.mem_addr_in  = a;
        bus.mem_we_in    = we;
        bus.mem_wdata_in = wd;
        bus.acc_tx_ready = txr;
        bus.acc_rx_valid = rxv;
        bus.acc_rx_data  = rxd;
        sel = (a[9:8] == 2'b01);
        off = a[7:0];
        nt = txq.size();
        nr = rxq.size();
        exp_rd = 64'd0;
        if (sel) begin
            case (off)
                8'h04: if (nr != 0) exp_rd = rxq[0];
                8'h0C: exp_rd = {40'd0, 8'(nr), 8'(nt), 4'd0,
                                 nt == DEPTH, nt == 0, nr == DEPTH, nr == 0};
                8'h10: exp_rd = 64'(err_m);
`ifdef MMIO_IRQ_EN
                8'h14: exp_rd = 64'(en_m);
`endif
                default: exp_rd = 64'd0;
            endcase
        end
        irq_n   = (en_m[0] && nr != 0) || (en_m[1] && nt == 0);
        tx_pop  = (nt != 0) && txr;
        tx_push = 0;
        rx_pop  = 0;
        rx_push = rxv && rdy_m;
        if (sel && we) begin
            case (off)
                8'h00: if (nt == DEPTH) err_m[0] = 1; else tx_push = 1;
                8'h08: if (nr == 0) err_m[1] = 1; else rx_pop = 1;
                8'h10: err_m = err_m & ~wd[1:0];
`ifdef MMIO_IRQ_EN
                8'h14: en_m = wd[1:0];
`endif
                default: ;
            endcase
        end
        if (tx_pop)  void'(txq.pop_front());
        if (tx_push) txq.push_back(wd);
        if (rx_pop)  void'(rxq.pop_front());
        if (rx_push) rxq.push_back(rxd);
        rdy_m = rxq.size() < DEPTH;
        irq_m = irq_n;
        @(posedge clk); #1;
        compare();
    endtask

    task automatic rd(input logic [9:0] a);
        step(a, 0, 64'd0, 0, 0, 64'd0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [63:0] d);
        step(a, 1, d, 0, 0, 64'd0);
    endtask

    logic [9:0] addrs [10] = '{10'h100, 10'h104, 10'h108, 10'h10C, 10'h110,
                               10'h114, 10'h000, 10'h204, 10'h30C, 10'h118};

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        do_reset(2);

        // reset status
        rd(10'h10C);
        chk("status_rst", bus.mem_rdata_out, 64'h5);
        chk("tx_valid_rst", 64'(bus.acc_tx_valid), 64'd0);
        chk("rx_ready_rst", 64'(bus.acc_rx_ready), 64'd1);

        // single push, then one beat drains it
        wr(10'h100, 64'hA5);
        chk("tx_valid_1", 64'(bus.acc_tx_valid), 64'd1);
        chk("tx_data_1", bus.acc_tx_data, 64'hA5);
        rd(10'h10C);
        chk("status_1", bus.mem_rdata_out, 64'h101);
        step(10'h000, 0, 64'd0, 1, 0, 64'd0);
        chk("tx_valid_drain", 64'(bus.acc_tx_valid), 64'd0);

        // overfill TX
        for (int i = 0; i < 9; i++) wr(10'h100, 64'(i + 16));
        rd(10'h10C);
        chk("status_full", bus.mem_rdata_out, 64'h809);
        rd(10'h110);
        chk("err_tx", bus.mem_rdata_out, 64'h1);
        wr(10'h110, 64'h1);
        rd(10'h110);
        chk("err_clr", bus.mem_rdata_out, 64'h0);
        for (int i = 0; i < DEPTH; i++) step(10'h000, 0, 64'd0, 1, 0, 64'd0);

        // RX path
        step(10'h000, 0, 64'd0, 0, 1, 64'h11);
        step(10'h000, 0, 64'd0, 0, 1, 64'h22);
        rd(10'h104);
        chk("rx_head", bus.mem_rdata_out, 64'h11);
        wr(10'h108, 64'd0);
        rd(10'h104);
        chk("rx_head2", bus.mem_rdata_out, 64'h22);
        wr(10'h108, 64'd0);
        wr(10'h108, 64'd0);
        rd(10'h10C);
        chk("rx_empty", bus.mem_rdata_out, 64'h5);
        rd(10'h110);
        chk("err_rx", bus.mem_rdata_out, 64'h2);
        wr(10'h110, 64'h3);

        // wrap TX 3x depth with ready toggling
        for (int i = 0; i < 3 * DEPTH * 2; i++) begin
            if (txq.size() < DEPTH) step(10'h100, 1, 64'(32'hC000 + i), i[0], 0, 64'd0);
            else step(10'h000, 0, 64'd0, i[0], 0, 64'd0);
        end
        for (int i = 0; i < 2 * DEPTH; i++) step(10'h000, 0, 64'd0, 1, 0, 64'd0);

        // unselected addresses
        wr(10'h000, 64'hDEAD);
        wr(10'h204, 64'hBEEF);
        rd(10'h10C);
        chk("status_unsel", bus.mem_rdata_out, 64'h5);
        rd(10'h000);
        chk("rd_unsel", bus.mem_rdata_out, 64'h0);

`ifdef MMIO_IRQ_EN
        wr(10'h114, 64'h1);
        step(10'h000, 0, 64'd0, 0, 1, 64'h77);
        rd(10'h000);
        chk("irq_set", 64'(irq), 64'd1);
        wr(10'h108, 64'd0);
        rd(10'h000);
        chk("irq_clr", 64'(irq), 64'd0);
        wr(10'h114, 64'h0);
`endif

        // randomized traffic with occasional mid-operation reset
        for (int i = 0; i < 3000; i++) begin
            bit ph;
            logic [9:0] a;
            ph = ((i / 150) % 2) == 1;
            if ($urandom_range(299) == 0) do_reset(1);
            a = ($urandom_range(7) == 0) ? 10'($urandom) : addrs[$urandom_range(9)];
            step(a, $urandom_range(1) == 1, {$urandom, $urandom},
                 ph ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0),
                 ph ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0),
                 {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
